// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external up/down counter: clears it, issues a fixed number of steps,
// supports pause/abort, and keeps a shadow copy of the counter value plus a sticky wrap flag.
module counter_seq_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [STEP_W-1:0] steps,
    input  logic              hold,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              cnt_rst,
    output logic              cnt_en,
    output logic              cnt_up_down,
    output logic [WIDTH-1:0]  count_o,
    output logic              wrap
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              wrap_q, wrap_d;

    logic              is_busy;
    logic              step;

    assign is_busy = (state_q == StClear) || (state_q == StRun) || (state_q == StPause);
    assign step    = (state_q == StRun) && !hold && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        count_d = count_q;
        wrap_d  = wrap_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dir_d   = dir;
                    rem_d   = steps;
                    wrap_d  = 1'b0;
                    state_d = (steps != '0) ? StClear : StDone;
                end
            end
            StClear: begin
                count_d = '0;
                state_d = StRun;
            end
            StRun: begin
                if (!abort) begin
                    if (hold) begin
                        state_d = StPause;
                    end else begin
                        if (dir_q) begin
                            count_d = count_q - 1'b1;
                            if (count_q == '0) wrap_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                            if (count_q == '1) wrap_d = 1'b1;
                        end
                        rem_d = rem_q - 1'b1;
                        if (rem_q == STEP_W'(1)) state_d = StDone;
                    end
                end
            end
            StPause: begin
                if (!hold) state_d = StRun;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides whatever the active state decided, including hold.
        if (is_busy && abort) begin
            count_d = '0;
            rem_d   = '0;
            state_d = StIdle;
        end
    end

    assign ready       = (state_q == StIdle);
    assign busy        = is_busy;
    assign done        = (state_q == StDone);
    assign cnt_rst     = (state_q == StClear) || (is_busy && abort);
    assign cnt_en      = step;
    assign cnt_up_down = dir_q;
    assign count_o     = count_q;
    assign wrap        = wrap_q;

endmodule
